rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares a single 3-to-8 decoded resource among 8 requesters.
- The grant is held as a registered 3-bit index and expanded to a one-hot grant vector.
- The decode follows 3-to-8 decoder semantics: an enable gates all outputs to zero.
- Sits between requesting agents and the shared resource; exactly one agent owns the resource at a time.

Parameters:
- HOLD_MAX, 4: maximum consecutive cycles one requester may hold the grant while others wait. Used only with ARB_TIMEOUT_EN. Legal range 1..255.
- CNT_W, 8: width of the internal hold counter. Must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  arbiter enable. 0 forces gnt to 0 and returns the FSM to IDLE.
- req  input  8  request vector. Bit i high means agent i wants the resource.
- gnt  output  8  one-hot grant, registered. 0 when no grant is active.
- gnt_idx  output  3  binary index of the current or last granted agent, registered.
- gnt_valid  output  1  high while gnt is nonzero.

Behaviour:
- Reset (async, immediate):
  - FSM = IDLE.
  - gnt = 8'h00, gnt_idx = 3'd0, gnt_valid = 0.
  - Priority pointer ptr = 3'd7, so the first search starts at agent 0.
  - hold_cnt = 0.
- Search function:
  - Returns the first i with req[i] = 1, scanning ptr+1, ptr+2, … mod 8 and wrapping. Agent ptr itself is examined last.
  - Result is combinational; all outputs are registered.
- gnt:
  - Equals the one-hot decode of gnt_idx (bit gnt_idx set) when gnt_valid = 1.
  - Otherwise 8'h00.
  - Never more than one bit set.
- IDLE:
  - If en = 1 and req != 0: next cycle gnt_idx = search result, gnt_valid = 1, ptr = search result, hold_cnt = 0, FSM goes to GRANT.
  - Latency from req to gnt is 1 clock.
  - Otherwise stay in IDLE with outputs held at reset values, except that gnt_idx keeps its last value.
- GRANT, checked in priority order:
  1. en = 0: next cycle gnt_valid = 0, gnt = 0, FSM goes to IDLE. The grant is dropped mid-hold and ptr is unchanged.
  2. req[gnt_idx] = 0 (release):
     - If any other request is pending, grant the search result (from ptr+1) next cycle. Back-to-back handover, no dead cycle; hold_cnt = 0.
     - Otherwise go to IDLE and deassert next cycle.
  3. Otherwise hold the grant and increment hold_cnt, saturating at 2^CNT_W - 1.
- Simultaneous events:
  - en falling in the same cycle as a release: en wins, FSM goes to IDLE.
  - A new request arriving in the same cycle as a release of another agent takes part in that cycle's search.
- Fairness: after agent k is granted, every other continuously requesting agent is granted before k again.
- Wrap-around: ptr = 7 searches starting at agent 0.
- Reset mid-grant: gnt clears asynchronously. ptr returns to 7, so agent 0 has top priority after reset.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - In GRANT, if req[gnt_idx] is still high and hold_cnt = HOLD_MAX-1, force re-arbitration next cycle using the search from ptr+1.
  - The current holder is considered last. If it is the only requester it is re-granted with hold_cnt = 0, and gnt stays high with no gap.
  - The en = 0 and release rules take precedence over timeout.
- Without the macro:
  - The grant is held until release or en = 0. HOLD_MAX is ignored.
  - The hold counter logic must not be synthesized.

Test Plan:
- Reset, then en=1, req=8'h00 for 3 cycles -> gnt=8'h00, gnt_valid=0, gnt_idx=0.
- en=1, req=8'h81 -> 1 cycle later gnt=8'h01, gnt_idx=0. Drop req[0] -> next cycle gnt=8'h80, gnt_idx=7 (handover with no gap). Drop req[7] -> next cycle gnt=0.
- req=8'hFF held, each grantee releases after 2 cycles and re-requests -> grant order 0,1,2,…,7,0 with gnt always one-hot.
- Grant active on agent 3 (gnt=8'h08), drive en=0 -> next cycle gnt=0 and FSM in IDLE. en=1 with req=8'h08 -> gnt=8'h08 again after 1 cycle.
- ARB_TIMEOUT_EN, HOLD_MAX=4, req=8'h0C held -> agent 2 granted for 4 cycles, then agent 3 for 4, then 2. With only req=8'h04 held, gnt=8'h04 continuously.
- Assert rst asynchronously mid-grant (gnt=8'h20) -> gnt=0 immediately. Deassert rst with req=8'h21 -> gnt=8'h01 first.

Source files
------------

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter for 8 requesters sharing one resource.
// Grant is a registered 3-bit index, decoded to a registered one-hot vector.
// Optional feature macro: ARB_TIMEOUT_EN (forces re-arbitration after
// HOLD_MAX consecutive cycles of holding while the holder keeps requesting).
module rr_arbiter8 #(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  // Elaboration-time parameter sanity check.
  generate
    if (HOLD_MAX < 1 || HOLD_MAX > 255 || (1 << CNT_W) <= HOLD_MAX) begin : g_bad_param
      $error("rr_arbiter8: illegal HOLD_MAX/CNT_W combination");
    end
  endgenerate

  state_t     r_state, w_state_nxt;
  logic [2:0] r_ptr, w_ptr_nxt;
  logic [2:0] r_gnt_idx, w_idx_nxt;
  logic       r_gnt_valid, w_valid_nxt;
  logic [7:0] r_gnt, w_gnt_nxt;
  logic [2:0] w_search;
  logic       w_take;
`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_hold_cnt, w_cnt_nxt;
`endif

  // Round-robin search from ptr+1; ptr itself is examined last (k=8 wraps to 0).
  // Scanning k downwards lets the nearest requester win the final assignment.
  always_comb begin
    w_search = r_ptr;
    for (int k = 8; k >= 1; k--) begin
      if (req[r_ptr + 3'(k)]) w_search = r_ptr + 3'(k);
    end
  end

  // Next-state logic: decide whether to take a new grant, hold, or drop.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_gnt_idx;
    w_valid_nxt = r_gnt_valid;
    w_take      = 1'b0;
`ifdef ARB_TIMEOUT_EN
    w_cnt_nxt   = r_hold_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        w_valid_nxt = 1'b0;
`ifdef ARB_TIMEOUT_EN
        w_cnt_nxt   = '0;
`endif
        if (en && (|req)) w_take = 1'b1;
      end
      S_GRANT: begin
        if (!en) begin
          // Drop mid-hold; ptr keeps its value so fairness resumes where it left off.
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
        end else if (!req[r_gnt_idx]) begin
          // Release: the holder no longer requests, so any remaining request
          // is another agent and is handed over without a dead cycle.
          if (|req) begin
            w_take = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_hold_cnt == CNT_W'(HOLD_MAX - 1)) begin
          // Holder considered last (ptr == holder), so it is re-granted only
          // when nobody else is waiting.
          w_take = 1'b1;
        end else if (r_hold_cnt != {CNT_W{1'b1}}) begin
          w_cnt_nxt = r_hold_cnt + 1'b1;
        end
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase

    if (w_take) begin
      w_state_nxt = S_GRANT;
      w_valid_nxt = 1'b1;
      w_idx_nxt   = w_search;
      w_ptr_nxt   = w_search;
`ifdef ARB_TIMEOUT_EN
      w_cnt_nxt   = '0;
`endif
    end
  end

  // One-hot decode of the next index, gated by the next valid (decoder enable).
  always_comb begin
    w_gnt_nxt = w_valid_nxt ? (8'b1 << w_idx_nxt) : 8'h00;
  end

  // State and output registers; async reset points ptr at 7 so agent 0 goes first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 3'd7;
      r_gnt_idx   <= 3'd0;
      r_gnt_valid <= 1'b0;
      r_gnt       <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt_idx   <= w_idx_nxt;
      r_gnt_valid <= w_valid_nxt;
      r_gnt       <= w_gnt_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Consecutive-hold counter, only present when the timeout is built in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_hold_cnt <= '0;
    else     r_hold_cnt <= w_cnt_nxt;
  end
`endif

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: vector table, hand-written corner
// sequences and randomized traffic against a behavioural reference model.
module tb_rr_arbiter8;
  localparam int HOLD_MAX = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int n_chk = 0;
  int n_err = 0;

  rr_arbiter8 #(.HOLD_MAX(HOLD_MAX), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_owner;   // -1: no grant
  int m_last;    // last granted agent (priority pointer)
  int m_idx;     // reported index
  int m_hold;    // consecutive hold cycles

  function automatic void model_reset();
    m_owner = -1; m_last = 7; m_idx = 0; m_hold = 0;
  endfunction

  function automatic void model_grant(input logic [7:0] r);
    for (int d = 1; d <= 8; d++) begin
      int a;
      a = (m_last + d) % 8;
      if (r[a]) begin
        m_owner = a; m_last = a; m_idx = a; m_hold = 0;
        return;
      end
    end
  endfunction

  function automatic void model_step(input logic e, input logic [7:0] r);
    if (!e) m_owner = -1;
    else if (m_owner < 0) begin
      if (r != 8'h00) model_grant(r);
    end else if (!r[m_owner]) begin
      if (r != 8'h00) model_grant(r);
      else m_owner = -1;
    end
`ifdef ARB_TIMEOUT_EN
    else if (m_hold == HOLD_MAX - 1) model_grant(r);
`endif
    else if (m_hold < 255) m_hold++;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic cmp_model(input string tag);
    logic [7:0] eg;
    eg = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    chk({tag, " gnt"}, {24'h0, gnt}, {24'h0, eg});
    chk({tag, " gnt_valid"}, {31'h0, gnt_valid}, {31'h0, (m_owner >= 0)});
    chk({tag, " gnt_idx"}, {29'h0, gnt_idx}, m_idx);
    chk({tag, " onehot"}, {31'h0, ($countones(gnt) <= 1)}, 32'h1);
  endtask

  // Drive inputs away from the edge, clock, update model, sample 1ns later.
  task automatic step(input logic e, input logic [7:0] r);
    en = e; req = r;
    @(posedge clk);
    model_step(e, r);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; req = 8'h00; rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset gnt", {24'h0, gnt}, 32'h0);
    chk("reset gnt_idx", {29'h0, gnt_idx}, 32'h0);
    chk("reset gnt_valid", {31'h0, gnt_valid}, 32'h0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // {en, req, expected gnt, expected gnt_idx, expected gnt_valid} after one clock
    tbl.push_back('{1'b1, 8'h00, 8'h00, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 8'h00, 8'h00, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 8'h00, 8'h00, 3'd0, 1'b0});
    tbl.push_back('{1'b1, 8'h81, 8'h01, 3'd0, 1'b1}); // ptr=7 -> agent 0 first
    tbl.push_back('{1'b1, 8'h80, 8'h80, 3'd7, 1'b1}); // handover, no gap
    tbl.push_back('{1'b1, 8'h00, 8'h00, 3'd7, 1'b0}); // release, idx kept
    tbl.push_back('{1'b1, 8'h08, 8'h08, 3'd3, 1'b1}); // ptr=7 wraps to 0..3
    tbl.push_back('{1'b0, 8'h08, 8'h00, 3'd3, 1'b0}); // en=0 drops grant
    tbl.push_back('{1'b1, 8'h08, 8'h08, 3'd3, 1'b1}); // re-grant after 1 clk
    tbl.push_back('{1'b1, 8'h28, 8'h08, 3'd3, 1'b1}); // holder keeps it
    tbl.push_back('{1'b1, 8'h20, 8'h20, 3'd5, 1'b1}); // release -> agent 5
    tbl.push_back('{1'b1, 8'h21, 8'h20, 3'd5, 1'b1}); // hold
    tbl.push_back('{1'b0, 8'h01, 8'h00, 3'd5, 1'b0}); // en=0 beats release
    tbl.push_back('{1'b1, 8'h01, 8'h01, 3'd0, 1'b1}); // from ptr=5 wraps to 0
    tbl.push_back('{1'b1, 8'h02, 8'h02, 3'd1, 1'b1}); // new req joins release search

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].req);
      chk($sformatf("vec%0d gnt", i), {24'h0, gnt}, {24'h0, tbl[i].gnt});
      chk($sformatf("vec%0d gnt_idx", i), {29'h0, gnt_idx}, {29'h0, tbl[i].idx});
      chk($sformatf("vec%0d gnt_valid", i), {31'h0, gnt_valid}, {31'h0, tbl[i].vld});
    end

    // Fairness: all request, each grantee releases after 2 cycles -> 0..7,0.
    do_reset();
    step(1'b1, 8'hFF);
    chk("rr first", {24'h0, gnt}, 32'h01);
    for (int k = 0; k < 9; k++) begin
      step(1'b1, 8'hFF);
      chk($sformatf("rr hold%0d", k), {24'h0, gnt}, {24'h0, 8'h01 << (k % 8)});
      cmp_model("rr hold");
      step(1'b1, 8'hFF & ~(8'h01 << (k % 8)));
      chk($sformatf("rr next%0d", k), {24'h0, gnt}, {24'h0, 8'h01 << ((k + 1) % 8)});
      cmp_model("rr next");
    end

`ifdef ARB_TIMEOUT_EN
    // Timeout: 2 and 3 alternate every HOLD_MAX cycles; sole requester stays.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      step(1'b1, 8'h0C);
      chk($sformatf("tmo c%0d", c), {24'h0, gnt},
          (((c / HOLD_MAX) % 2) == 0) ? 32'h04 : 32'h08);
    end
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 8'h04);
      chk($sformatf("tmo solo c%0d", c), {24'h0, gnt}, 32'h04);
    end
`endif

    // Asynchronous reset mid-grant.
    do_reset();
    step(1'b1, 8'h20);
    chk("pre-rst gnt", {24'h0, gnt}, 32'h20);
    #3 rst = 1'b1;
    #1;
    chk("async rst gnt", {24'h0, gnt}, 32'h0);
    chk("async rst valid", {31'h0, gnt_valid}, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 8'h21);
    chk("post-rst gnt", {24'h0, gnt}, 32'h01);
    chk("post-rst idx", {29'h0, gnt_idx}, 32'h0);

    // Randomized traffic against the model.
    do_reset();
    begin
      logic [7:0] r;
      logic       e;
      r = 8'h00;
      for (int n = 0; n < 400; n++) begin
        case ($urandom_range(0, 7))
          0, 1: r = 8'($urandom);
          2:    r = r ^ (8'h01 << $urandom_range(0, 7));
          3:    if (m_owner >= 0) r[m_owner] = 1'b0;
          4:    r = 8'h00;
          default: ;
        endcase
        e = ($urandom_range(0, 15) != 0);
        step(e, r);
        cmp_model($sformatf("rand%0d", n));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
